inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  Pipelined RV32I instruction encoder: field-level operands (opcode, regs, funct, immediate) in,
//  packed 32-bit instruction word out, tagged with a sequential IMEM byte address.
//  Encode-side counterpart of the immediate decode path; feeds the program loader / IMEM write
//  port and bench stimulus. 2-stage valid/ready pipeline, full throughput.
// PARAMETERS
//  DATA_WIDTH  32  width of in_imm and out_inst
//  ADDR_WIDTH  32  width of out_addr
//  BASE_ADDR   0   out_addr value after reset
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   synchronous, active-high reset
//  in_valid    in   1   operand bundle valid
//  in_ready    out  1   encoder accepts bundle this cycle
//  in_opcode   in   7   RV32I opcode
//  in_rd       in   5   destination register
//  in_rs1      in   5   source register 1
//  in_rs2      in   5   source register 2
//  in_funct3   in   3   funct3
//  in_funct7   in   7   funct7 (R-type; I-type shifts)
//  in_imm      in   32  immediate as full signed byte value (branch/jump offsets unshifted)
//  out_valid   out  1   encoded word valid
//  out_ready   in   1   consumer accepts word
//  out_inst    out  32  encoded instruction
//  out_addr    out  ADDR_WIDTH  IMEM byte address of out_inst
//  out_err     out  1   immediate out of range / unknown opcode (see CONFIGURATION)
// BEHAVIOUR
//  Reset: s1_valid=s2_valid=0, out_valid=0, out_inst=0, out_err=0, out_addr=BASE_ADDR.
//  Reset mid-operation drops all in-flight words; no partial output.
//  Handshake: transfer when valid&&ready. s2_rdy=!s2_valid||out_ready; in_ready=!s1_valid||s2_rdy.
//  in_ready is combinational from out_ready; out_valid/out_inst/out_addr/out_err are registers only.
//  S1 registers the operand bundle; S2 registers the encoded word. Latency 2 cycles from in
//  handshake to out_valid with out_ready held high; 1 word/cycle sustained.
//  Output held stable while out_valid&&!out_ready. Order preserved; no drops, no duplicates.
//  out_addr: address of the current word; +4 after each out handshake; wraps modulo 2^ADDR_WIDTH.
//  Encoding by opcode:
//   R 0110011: f7|rs2|rs1|f3|rd|op
//   I 0010011/0000011/1100111: imm[11:0]|rs1|f3|rd|op
//     Exception: 0010011 with f3=001/101 uses f7|imm[4:0]|rs1|f3|rd|op
//   S 0100011: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
//   B 1100011: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
//   U 0110111/0010111: imm[31:12]|rd|op
//   J 1101111: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
//   Any other opcode: out_inst=32'h0000_0013 (NOP).
//  Field bits not used by a format are ignored (e.g. rs2 for I-type).
// CONFIGURATION
//  IMM_RANGE_CHECK_EN defined -> legality checks in S1->S2 encode:
//   I/S: imm in [-2048,2047]
//   B: imm in [-4096,4094] and imm[0]=0
//   J: imm in [-2^20,2^20-2] and imm[0]=0
//   U: imm[11:0]=0
//   shift: imm[31:5]=0
//   Violation or unknown opcode: out_inst=32'h0000_0013, out_err=1 with that word; still consumes an address.
//  IMM_RANGE_CHECK_EN undefined -> excess imm bits silently truncated; out_err tied 0; unknown opcode -> NOP.
// TESTING
//  addi x1,x0,5 (op 0010011,rd1,f3 0,imm 5) -> out_inst 0x00500093, out_addr 0x0, 2 cycles later
//  beq x1,x2,-8 (op 1100011,rs1 1,rs2 2,imm -8) -> 0xfe208ce3; sw x5,12(x2) -> 0x00512623
//  lui x3 imm 0x12345000 -> 0x123451b7; jal x1 imm 2048 -> 0x001000ef
//  3 bundles, out_ready=0: in_ready low after 2 accepted
//    -> release: 3 words in order, out_addr 0x0,0x4,0x8
//  Back-to-back 8 bundles, out_ready=1 -> 8 consecutive out_valid cycles
//  rst pulse with 2 words in flight -> out_valid=0 next cycle, next word at out_addr=BASE_ADDR
//  IMM_RANGE_CHECK_EN: addi imm 2048 -> 0x00000013, out_err=1
//    Without the macro: 0x80000093, out_err=0

Source files
------------

// File: rtl/inst_encoder.sv
`timescale 1ns/1ps
// Two-stage RV32I instruction encoder: operand fields in, packed word plus IMEM byte address out.
// Define IMM_RANGE_CHECK_EN to turn illegal immediates and unknown opcodes into a flagged NOP.
module inst_encoder #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_err
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_JALR   = 7'b1100111,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } bundle_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    bundle_t     s1;
    logic        s1_valid;
    logic        s2_valid;
    logic        s2_rdy;
    logic [31:0] raw_inst;
    logic [31:0] enc_inst;
    logic        enc_err;
    logic        is_shift;

    assign s2_rdy    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_rdy;
    assign out_valid = s2_valid;
    assign is_shift  = (s1.funct3 == 3'b001) || (s1.funct3 == 3'b101);

    // Pure format packing; legality is judged separately so the default build stays free of it.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        raw_inst = NOP;
        case (s1.opcode)
            OP_R:
                raw_inst = {s1.funct7, s1.rs2, s1.rs1, s1.funct3, s1.rd, s1.opcode};
            OP_IMM, OP_LOAD, OP_JALR:
                if (s1.opcode == OP_IMM && is_shift)
                    raw_inst = {s1.funct7, s1.imm[4:0], s1.rs1, s1.funct3, s1.rd, s1.opcode};
                else
                    raw_inst = {s1.imm[11:0], s1.rs1, s1.funct3, s1.rd, s1.opcode};
            OP_STORE:
                raw_inst = {s1.imm[11:5], s1.rs2, s1.rs1, s1.funct3, s1.imm[4:0], s1.opcode};
            OP_BRANCH:
                raw_inst = {s1.imm[12], s1.imm[10:5], s1.rs2, s1.rs1, s1.funct3,
                            s1.imm[4:1], s1.imm[11], s1.opcode};
            OP_LUI, OP_AUIPC:
                raw_inst = {s1.imm[31:12], s1.rd, s1.opcode};
            OP_JAL:
                raw_inst = {s1.imm[20], s1.imm[10:1], s1.imm[11], s1.imm[19:12], s1.rd, s1.opcode};
            default:
                raw_inst = NOP;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic imm_bad;
    logic fits_12;
    logic fits_13;
    logic fits_21;

    // A signed value fits in N bits when every bit from N-1 upward equals the sign bit.
    assign fits_12 = (&s1.imm[31:11]) || !(|s1.imm[31:11]);
    assign fits_13 = (&s1.imm[31:12]) || !(|s1.imm[31:12]);
    assign fits_21 = (&s1.imm[31:20]) || !(|s1.imm[31:20]);

    always_comb begin
        imm_bad = 1'b1;
        case (s1.opcode)
            OP_R:
                imm_bad = 1'b0;
            OP_IMM, OP_LOAD, OP_JALR:
                if (s1.opcode == OP_IMM && is_shift)
                    imm_bad = |s1.imm[31:5];
                else
                    imm_bad = !fits_12;
            OP_STORE:
                imm_bad = !fits_12;
            OP_BRANCH:
                imm_bad = !fits_13 || s1.imm[0];
            OP_LUI, OP_AUIPC:
                imm_bad = |s1.imm[11:0];
            OP_JAL:
                imm_bad = !fits_21 || s1.imm[0];
            default:
                imm_bad = 1'b1;
        endcase
    end

    assign enc_inst = imm_bad ? NOP : raw_inst;
    assign enc_err  = imm_bad;
`else
    assign enc_inst = raw_inst;
    assign enc_err  = 1'b0;
`endif

    // NOTE: the S1 operand bundle is pure datapath qualified by s1_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1.opcode <= in_opcode;
            s1.rd     <= in_rd;
            s1.rs1    <= in_rs1;
            s1.rs2    <= in_rs2;
            s1.funct3 <= in_funct3;
            s1.funct7 <= in_funct7;
            s1.imm    <= 32'(in_imm);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            out_inst <= '0;
            out_err  <= 1'b0;
            out_addr <= BASE_ADDR;
        end else begin
            // in_ready implies S1 is empty or draining this cycle, so it simply takes in_valid.
            if (in_ready)
                s1_valid <= in_valid;
            if (s2_rdy)
                s2_valid <= s1_valid;
            if (s2_rdy && s1_valid) begin
                out_inst <= DATA_WIDTH'(enc_inst);
                out_err  <= enc_err;
            end
            if (s2_valid && out_ready)
                out_addr <= out_addr + ADDR_WIDTH'(4);
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
`timescale 1ns/1ps
// Scoreboard bench for inst_encoder: reference encoder, spec vectors, backpressure, reset and address wrap.
module tb_inst_encoder;

    localparam logic [31:0] BASE = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;

    always #5 clk = ~clk;

    inst_encoder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_opcode(in_opcode),
        .in_rd    (in_rd),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_funct3(in_funct3),
        .in_funct7(in_funct7),
        .in_imm   (in_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst (out_inst),
        .out_addr (out_addr),
        .out_err  (out_err)
    );

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } bundle_t;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic        bad;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
        int          cyc;
    } obs_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    obs_t        obs_q[$];
    logic [31:0] exp_addr;

    function automatic bundle_t mk(input logic [6:0] op, input int rd, input int rs1, input int rs2,
                                   input logic [2:0] f3, input logic [6:0] f7, input int imm);
        bundle_t b;
        b.op  = op;
        b.rd  = 5'(rd);
        b.rs1 = 5'(rs1);
        b.rs2 = 5'(rs2);
        b.f3  = f3;
        b.f7  = f7;
        b.imm = 32'(imm);
        return b;
    endfunction

    // Reference encoder: legality judged with signed integer range compares.
    function automatic exp_t model(input bundle_t b);
        exp_t        e;
        logic [31:0] i;
        int          s;
        i = b.imm;
        s = signed'(b.imm);
        e.inst = NOP;
        e.err  = 1'b0;
        e.bad  = 1'b1;
        e.cyc  = 0;
        case (b.op)
            7'b0110011: begin
                e.inst = {b.f7, b.rs2, b.rs1, b.f3, b.rd, b.op};
                e.bad  = 1'b0;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                if (b.op == 7'b0010011 && (b.f3 == 3'b001 || b.f3 == 3'b101)) begin
                    e.inst = {b.f7, i[4:0], b.rs1, b.f3, b.rd, b.op};
                    e.bad  = (i >> 5) != 0;
                end else begin
                    e.inst = {i[11:0], b.rs1, b.f3, b.rd, b.op};
                    e.bad  = (s < -2048) || (s > 2047);
                end
            end
            7'b0100011: begin
                e.inst = {i[11:5], b.rs2, b.rs1, b.f3, i[4:0], b.op};
                e.bad  = (s < -2048) || (s > 2047);
            end
            7'b1100011: begin
                e.inst = {i[12], i[10:5], b.rs2, b.rs1, b.f3, i[4:1], i[11], b.op};
                e.bad  = (s < -4096) || (s > 4094) || i[0];
            end
            7'b0110111, 7'b0010111: begin
                e.inst = {i[31:12], b.rd, b.op};
                e.bad  = i[11:0] != 0;
            end
            7'b1101111: begin
                e.inst = {i[20], i[10:1], i[11], i[19:12], b.rd, b.op};
                e.bad  = (s < -1048576) || (s > 1048574) || i[0];
            end
            default: e.inst = NOP;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        if (e.bad) begin
            e.inst = NOP;
            e.err  = 1'b1;
        end
`endif
        return e;
    endfunction

    function automatic bundle_t rand_bundle();
        logic [6:0] ops[10];
        bundle_t    b;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1011011};
        b = mk(ops[$urandom_range(0, 9)], int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), 3'($urandom), 7'($urandom), 0);
        case ($urandom_range(0, 3))
            0: b.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
            1: b.imm = $urandom;
            2: b.imm = 32'($urandom_range(0, 40));
            default: b.imm = $urandom & 32'hFFFF_F000;
        endcase
        return b;
    endfunction

    // One clock cycle: drive at the falling edge, record both handshakes, advance to the next falling edge.
    task automatic step(input logic v, input bundle_t b, input logic ordy);
        obs_t o;
        exp_t e;
        in_valid  = v;
        in_opcode = b.op;
        in_rd     = b.rd;
        in_rs1    = b.rs1;
        in_rs2    = b.rs2;
        in_funct3 = b.f3;
        in_funct7 = b.f7;
        in_imm    = b.imm;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            o.inst = out_inst;
            o.addr = out_addr;
            o.err  = out_err;
            o.cyc  = cyc;
            obs_q.push_back(o);
        end
        if (in_valid && in_ready) begin
            e = model(b);
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        exp_addr = BASE;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_err !== 1'b0 || out_addr !== BASE || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b inst=%h err=%b addr=%h in_ready=%b, want 0 00000000 0 %h 1",
                     out_valid, out_inst, out_err, out_addr, in_ready, BASE);
        end
    endtask

    task automatic test_vectors();
        bundle_t     vb[9];
        logic [31:0] vi[9];
        logic        ve[9];
        obs_t        o;
        exp_t        e;
        vb[0] = mk(7'b0010011, 1, 0, 0, 3'b000, 7'h00, 5);          vi[0] = 32'h00500093; ve[0] = 1'b0;
        vb[1] = mk(7'b1100011, 0, 1, 2, 3'b000, 7'h00, -8);         vi[1] = 32'hfe208ce3; ve[1] = 1'b0;
        vb[2] = mk(7'b0100011, 0, 2, 5, 3'b010, 7'h00, 12);         vi[2] = 32'h00512623; ve[2] = 1'b0;
        vb[3] = mk(7'b0110111, 3, 0, 0, 3'b000, 7'h00, 'h12345000); vi[3] = 32'h123451b7; ve[3] = 1'b0;
        vb[4] = mk(7'b1101111, 1, 0, 0, 3'b000, 7'h00, 2048);       vi[4] = 32'h001000ef; ve[4] = 1'b0;
        vb[5] = mk(7'b0010011, 1, 1, 0, 3'b001, 7'h00, 3);          vi[5] = 32'h00309093; ve[5] = 1'b0;
        vb[6] = mk(7'b0010011, 2, 2, 0, 3'b101, 7'h20, 4);          vi[6] = 32'h40415113; ve[6] = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        vb[7] = mk(7'b0010011, 1, 0, 0, 3'b000, 7'h00, 2048);       vi[7] = NOP;          ve[7] = 1'b1;
        vb[8] = mk(7'b1111111, 1, 2, 3, 3'b000, 7'h00, 0);          vi[8] = NOP;          ve[8] = 1'b1;
`else
        vb[7] = mk(7'b0010011, 1, 0, 0, 3'b000, 7'h00, 2048);       vi[7] = 32'h80000093; ve[7] = 1'b0;
        vb[8] = mk(7'b1111111, 1, 2, 3, 3'b000, 7'h00, 0);          vi[8] = NOP;          ve[8] = 1'b0;
`endif
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(1'b1, vb[k], 1'b1);
            repeat (3) step(1'b0, vb[k], 1'b1);
            checks++;
            if (obs_q.size() != 1 || exp_q.size() != 1) begin
                errors++;
                $display("FAIL vec%0d_count: got %0d words for %0d accepted, want 1 and 1", k, obs_q.size(), exp_q.size());
                obs_q.delete();
                exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                if (o.inst !== vi[k] || o.err !== ve[k] || o.addr !== exp_addr) begin
                    errors++;
                    $display("FAIL vec%0d_word: inst=%h err=%b addr=%h, want %h %b %h",
                             k, o.inst, o.err, o.addr, vi[k], ve[k], exp_addr);
                end
                checks++;
                if (o.cyc - e.cyc != 2) begin
                    errors++;
                    $display("FAIL vec%0d_latency: %0d cycles, want 2", k, o.cyc - e.cyc);
                end
            end
            exp_addr += 32'd4;
        end
    endtask

    task automatic test_backpressure();
        bundle_t b[3];
        exp_t    held;
        obs_t    o;
        exp_t    e;
        int      idx = 0;
        b[0] = mk(7'b0110011, 3, 1, 2, 3'b000, 7'h20, 0);
        b[1] = mk(7'b0000011, 4, 5, 0, 3'b010, 7'h00, -4);
        b[2] = mk(7'b1100011, 0, 6, 7, 3'b001, 7'h00, 4094);
        held = model(b[0]);
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step(idx < 3, b[idx < 3 ? idx : 2], 1'b0);
            idx = exp_q.size();
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (exp_q.size() != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_accept: accepted=%0d in_ready=%b, want 2 0", exp_q.size(), in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_inst !== held.inst || out_addr !== BASE) begin
            errors++;
            $display("FAIL stall_hold: valid=%b inst=%h addr=%h, want 1 %h %h", out_valid, out_inst, out_addr, held.inst, BASE);
        end
        for (int c = 0; c < 8; c++) begin
            step(idx < 3, b[idx < 3 ? idx : 2], 1'b1);
            idx = exp_q.size() + obs_q.size() - obs_q.size();
            if (idx < 3 && exp_q.size() == 0) idx = 3;
        end
        checks++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            errors++;
            $display("FAIL release_count: got %0d words for %0d accepted, want 3", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.inst !== e.inst || o.err !== e.err || o.addr !== exp_addr) begin
                errors++;
                $display("FAIL release_word: inst=%h err=%b addr=%h, want %h %b %h", o.inst, o.err, o.addr, e.inst, e.err, exp_addr);
            end
            exp_addr += 32'd4;
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        int   first_cyc = 0;
        int   run = 0;
        do_reset();
        for (int c = 0; c < 12; c++)
            step(c < 8, rand_bundle(), 1'b1);
        checks++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d words for %0d accepted, want 8", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (run == 0) first_cyc = o.cyc;
            if (o.cyc == first_cyc + run) run++;
            checks++;
            if (o.inst !== e.inst || o.err !== e.err || o.addr !== exp_addr) begin
                errors++;
                $display("FAIL b2b_word: inst=%h err=%b addr=%h, want %h %b %h", o.inst, o.err, o.addr, e.inst, e.err, exp_addr);
            end
            exp_addr += 32'd4;
        end
        checks++;
        if (run != 8) begin
            errors++;
            $display("FAIL b2b_throughput: %0d consecutive out_valid cycles, want 8", run);
        end
    endtask

    task automatic test_random();
        bundle_t b;
        obs_t    o;
        exp_t    e;
        int      accepted = 0;
        int      illegal = 0;
        do_reset();
        b = rand_bundle();
        for (int c = 0; c < 80; c++) begin
            step($urandom_range(0, 3) != 0, b, $urandom_range(0, 9) < 7);
            if (exp_q.size() + accepted > accepted && exp_q.size() > 0 && exp_q[$].cyc == cyc - 1) begin
                if (exp_q[$].bad) illegal++;
                b = rand_bundle();
            end
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                accepted++;
                checks++;
                if (o.inst !== e.inst || o.err !== e.err || o.addr !== exp_addr) begin
                    errors++;
                    $display("FAIL random_word: inst=%h err=%b addr=%h, want %h %b %h", o.inst, o.err, o.addr, e.inst, e.err, exp_addr);
                end
                exp_addr += 32'd4;
            end
        end
        for (int c = 0; c < 6; c++)
            step(1'b0, b, 1'b1);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.inst !== e.inst || o.err !== e.err || o.addr !== exp_addr) begin
                errors++;
                $display("FAIL random_drain: inst=%h err=%b addr=%h, want %h %b %h", o.inst, o.err, o.addr, e.inst, e.err, exp_addr);
            end
            exp_addr += 32'd4;
        end
        checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_leftover: %0d words and %0d accepted unmatched, want 0 0", obs_q.size(), exp_q.size());
        end
        $display("random: %0d bundles with an out-of-range immediate or unknown opcode", illegal);
    endtask

    task automatic test_reset_midflight();
        bundle_t b0;
        bundle_t b1;
        bundle_t b2;
        exp_t    want;
        obs_t    o;
        b0 = mk(7'b0010011, 1, 0, 0, 3'b000, 7'h00, 1);
        b1 = mk(7'b0010011, 2, 0, 0, 3'b000, 7'h00, 2);
        b2 = mk(7'b0110111, 9, 0, 0, 3'b000, 7'h00, 'h7FFFF000);
        want = model(b2);
        do_reset();
        step(1'b1, b0, 1'b0);
        step(1'b1, b1, 1'b0);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== BASE) begin
            errors++;
            $display("FAIL midflight_reset: valid=%b addr=%h, want 0 %h", out_valid, out_addr, BASE);
        end
        exp_q.delete();
        obs_q.delete();
        step(1'b1, b2, 1'b1);
        repeat (4) step(1'b0, b2, 1'b1);
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL midflight_count: got %0d words, want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            checks++;
            if (o.inst !== want.inst || o.err !== want.err || o.addr !== BASE) begin
                errors++;
                $display("FAIL midflight_word: inst=%h err=%b addr=%h, want %h %b %h", o.inst, o.err, o.addr, want.inst, want.err, BASE);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_opcode = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_funct3 = '0;
        in_funct7 = '0;
        in_imm    = '0;
        @(negedge clk);
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns");
        $fatal(1);
    end

endmodule
